// File: rtl/a51_pkg.sv
// Shared types and constants for the A5/1 burst packing path.
package a51_pkg;

  localparam int unsigned A51_BURST_BITS = 114;
  localparam int unsigned A51_BYTE_W     = 8;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StCollect = 1'b1
  } a51_pack_state_t;

  typedef struct packed {
    logic                  last;
    logic [3:0]            nbits;
    logic [A51_BYTE_W-1:0] data;
  } a51_byte_t;

  // Number of meaningful bits in the closing byte of a burst
  function automatic logic [3:0] a51_last_nbits(int unsigned burst_bits);
    int unsigned rem;
    rem = burst_bits % A51_BYTE_W;
    return (rem == 0) ? 4'd8 : 4'(rem);
  endfunction

endpackage

// File: rtl/a51_byte_fifo.sv
// Small byte FIFO; the head entry drives the packer output directly.
// Push on a full FIFO is accepted only when a pop happens in the same cycle.
module a51_byte_fifo
  import a51_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  a51_byte_t wdata_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      valid_o,
  output a51_byte_t rdata_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  a51_byte_t       mem_q [Depth];
  a51_byte_t       mem_d [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer, occupancy and storage update
  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q != CntW'(Depth)) || do_pop);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (do_pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign full_o  = (cnt_q == CntW'(Depth));
  assign valid_o = (cnt_q != '0);
  assign rdata_o = mem_q[rptr_q];

endmodule

// File: rtl/a51_burst_packer.sv
// Frames the serial A5/1 cipher stream into bursts and packs them into bytes.
// Build option A51_PACK_FIFO_EN: 4-entry output FIFO instead of a single output register.
module a51_burst_packer
  import a51_pkg::*;
#(
  parameter int unsigned BURST_BITS = A51_BURST_BITS,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       bit_in,
  input  logic       bit_vld,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [3:0] out_nbits,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned     CntW      = $clog2(BURST_BITS + 1);
  localparam logic [CntW-1:0] LastIdx   = CntW'(BURST_BITS - 1);
  localparam logic [3:0]      LastNbits = a51_last_nbits(BURST_BITS);
  localparam int unsigned     PadShift  = A51_BYTE_W - 32'(LastNbits);

  a51_pack_state_t state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d, base_bitcnt;
  logic [CntW-1:0] burstcnt_q, burstcnt_d, base_burstcnt;
  logic [7:0]      shreg_q, shreg_d, base_shreg, shreg_n;
  logic            overflow_q, overflow_d;
  logic            take_bit, push, push_last, pop, drop;
  a51_byte_t       push_byte, head;

  // Bit capture and byte assembly; start restarts counting from this very cycle
  always_comb begin
    base_bitcnt   = start ? '0 : bitcnt_q;
    base_burstcnt = start ? '0 : burstcnt_q;
    base_shreg    = start ? '0 : shreg_q;
    take_bit      = bit_vld && (start || (state_q == StCollect));
    shreg_n       = (MSB_FIRST != 0) ? {base_shreg[6:0], bit_in} : {bit_in, base_shreg[7:1]};
    bitcnt_d      = base_bitcnt;
    burstcnt_d    = base_burstcnt;
    shreg_d       = base_shreg;
    push          = 1'b0;
    push_last     = 1'b0;
    if (take_bit) begin
      bitcnt_d   = base_bitcnt + 3'd1;
      burstcnt_d = base_burstcnt + 1'b1;
      shreg_d    = shreg_n;
      push_last  = (base_burstcnt == LastIdx);
      push       = push_last || (base_bitcnt == 3'd7);
    end
    // Stale bits from the previous byte fall off when the partial byte is justified
    push_byte       = '0;
    push_byte.last  = push_last;
    push_byte.nbits = push_last ? LastNbits : 4'd8;
    if (!push_last) begin
      push_byte.data = shreg_n;
    end else if (MSB_FIRST != 0) begin
      push_byte.data = shreg_n << PadShift;
    end else begin
      push_byte.data = shreg_n >> PadShift;
    end
  end

  // FSM next state: the closing bit wins over a coincident start
  always_comb begin
    state_d = state_q;
    if (take_bit && push_last) begin
      state_d = StIdle;
    end else if (start) begin
      state_d = StCollect;
    end
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == StCollect);
  end

  assign pop = out_valid && out_ready;

`ifdef A51_PACK_FIFO_EN
  logic fifo_full;

  a51_byte_fifo #(
    .Depth (4)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (push_byte),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .valid_o (out_valid),
    .rdata_o (head)
  );

  assign drop = push && fifo_full && !pop;
`else
  a51_byte_t out_q, out_d;
  logic      valid_q, valid_d;

  // Single output register; contents held while the sink stalls
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q && !pop;
    if (push && (!valid_q || pop)) begin
      out_d   = push_byte;
      valid_d = 1'b1;
    end
  end

  // Output register state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign head      = out_q;
  assign out_valid = valid_q;
  assign drop      = push && valid_q && !pop;
`endif

  // Sticky overflow; a drop in the same cycle as start still registers
  always_comb begin
    overflow_d = (overflow_q && !start) || drop;
  end

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bitcnt_q   <= '0;
      burstcnt_q <= '0;
      shreg_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      burstcnt_q <= burstcnt_d;
      shreg_q    <= shreg_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_data  = head.data;
  assign out_last  = head.last;
  assign out_nbits = head.nbits;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_a51_burst_packer.sv
// Self-checking bench for a51_burst_packer: three configurations, directed and random bursts.
module tb_a51_burst_packer;

`ifdef A51_PACK_FIFO_EN
  localparam int StoreDepth = 4;
`else
  localparam int StoreDepth = 1;
`endif
  localparam int OvfBit = 8 * (StoreDepth + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      start, bit_in, bit_vld, out_ready;
  logic [2:0][7:0] out_data;
  logic [2:0][3:0] out_nbits;
  logic [2:0]      out_valid, out_last, busy, overflow;

  int          vectors = 0;
  int          miscompares = 0;
  int          low_run = 0;
  bit          ready_rand = 1'b0;
  bit          cur_bits[$];
  logic [14:0] obs_q[$];
  logic [14:0] exp_q[$];

  always #5 clk = ~clk;

  a51_burst_packer #(.BURST_BITS(114), .MSB_FIRST(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .bit_in(bit_in[0]), .bit_vld(bit_vld[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_last(out_last[0]), .out_nbits(out_nbits[0]), .busy(busy[0]), .overflow(overflow[0])
  );

  a51_burst_packer #(.BURST_BITS(8), .MSB_FIRST(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .bit_in(bit_in[1]), .bit_vld(bit_vld[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_last(out_last[1]), .out_nbits(out_nbits[1]), .busy(busy[1]), .overflow(overflow[1])
  );

  a51_burst_packer #(.BURST_BITS(13), .MSB_FIRST(0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .bit_in(bit_in[2]), .bit_vld(bit_vld[2]),
    .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_last(out_last[2]), .out_nbits(out_nbits[2]), .busy(busy[2]), .overflow(overflow[2])
  );

  // Record every accepted byte as {dut, last, nbits, data}
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst_n && out_valid[d] && out_ready[d]) begin
        obs_q.push_back({2'(d), out_last[d], out_nbits[d], out_data[d]});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step(int d, bit st, bit vld, bit b);
    start[d]   = st;
    bit_vld[d] = vld;
    bit_in[d]  = b;
    if (ready_rand) begin
      if (low_run >= 3 || $urandom_range(0, 3) != 0) begin
        out_ready[d] = 1'b1;
        low_run      = 0;
      end else begin
        out_ready[d] = 1'b0;
        low_run++;
      end
    end
    @(posedge clk);
    #1;
    start[d]   = 1'b0;
    bit_vld[d] = 1'b0;
    bit_in[d]  = 1'b0;
  endtask

  task automatic drain(int d);
    ready_rand   = 1'b0;
    out_ready[d] = 1'b1;
    repeat (12) step(d, 1'b0, 1'b0, 1'b0);
  endtask

  // Reference: cut the burst into 8-bit groups, pad the tail with zeros
  task automatic model_burst(int d, int n, bit msb);
    for (int k = 0; k * 8 < n; k++) begin
      logic [7:0] data;
      int         cnt;
      data = '0;
      cnt  = (n - k * 8 > 8) ? 8 : n - k * 8;
      for (int j = 0; j < cnt; j++) begin
        if (msb) data[7 - j] = cur_bits[k * 8 + j];
        else     data[j]     = cur_bits[k * 8 + j];
      end
      exp_q.push_back({2'(d), 1'(k * 8 + 8 >= n), 4'(cnt), data});
    end
  endtask

  task automatic compare(string tag);
    check($sformatf("%s count", tag), obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      check($sformatf("%s byte", tag), obs_q.pop_front(), exp_q.pop_front());
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_burst(int d, int n, bit msb, int gap_pct, bit rr, string tag);
    cur_bits.delete();
    ready_rand = rr;
    step(d, 1'b1, 1'b0, 1'b0);
    check($sformatf("%s busy rise", tag), busy[d], 1);
    for (int i = 0; i < n; i++) begin
      bit b;
      b = 1'($urandom);
      for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++) begin
        step(d, 1'b0, 1'b0, 1'($urandom));
      end
      cur_bits.push_back(b);
      step(d, 1'b0, 1'b1, b);
    end
    drain(d);
    check($sformatf("%s busy fall", tag), busy[d], 0);
    model_burst(d, n, msb);
    compare(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = '0;
    bit_in    = '0;
    bit_vld   = '1;
    out_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset%0d valid", d), out_valid[d], 0);
      check($sformatf("reset%0d busy", d), busy[d], 0);
      check($sformatf("reset%0d overflow", d), overflow[d], 0);
      check($sformatf("reset%0d data", d), out_data[d], 0);
      check($sformatf("reset%0d nbits", d), out_nbits[d], 0);
      check($sformatf("reset%0d last", d), out_last[d], 0);
    end
    bit_vld = '0;
    rst_n   = 1'b1;
    step(0, 1'b0, 1'b0, 1'b0);

    // Nominal: alternating 1,0 over a full 114-bit burst
    cur_bits.delete();
    step(0, 1'b1, 1'b0, 1'b0);
    check("nominal busy rise", busy[0], 1);
    for (int i = 0; i < 114; i++) begin
      cur_bits.push_back(i % 2 == 0);
      step(0, 1'b0, 1'b1, i % 2 == 0);
      if (i == 7) begin
        check("nominal latency valid", out_valid[0], 1);
        check("nominal first byte", out_data[0], 8'hAA);
      end
      if (i == 113) begin
        check("nominal busy fall", busy[0], 0);
        check("nominal last data", out_data[0], 8'h80);
        check("nominal last nbits", out_nbits[0], 2);
        check("nominal last flag", out_last[0], 1);
      end
    end
    drain(0);
    model_burst(0, 114, 1'b1);
    compare("nominal");

    // LSB-first, 8-bit burst
    cur_bits.delete();
    step(1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cur_bits.push_back(i == 0);
      step(1, 1'b0, 1'b1, i == 0);
    end
    check("lsb8 data", out_data[1], 8'h01);
    check("lsb8 last", out_last[1], 1);
    check("lsb8 nbits", out_nbits[1], 8);
    drain(1);
    model_burst(1, 8, 1'b0);
    compare("lsb8");

    // Backpressure: sink stalled for a whole all-ones burst
    out_ready[0] = 1'b0;
    step(0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 114; i++) begin
      step(0, 1'b0, 1'b1, 1'b1);
      if (i == OvfBit - 2) check("bp overflow early", overflow[0], 0);
      if (i == OvfBit - 1) begin
        check("bp overflow set", overflow[0], 1);
        check("bp held valid", out_valid[0], 1);
      end
    end
    check("bp held data", out_data[0], 8'hFF);
    check("bp held nbits", out_nbits[0], 8);
    check("bp held last", out_last[0], 0);
    drain(0);
    for (int k = 0; k < StoreDepth; k++) exp_q.push_back({2'd0, 1'b0, 4'd8, 8'hFF});
    compare("bp drain");
    check("bp overflow sticky", overflow[0], 1);
    step(0, 1'b1, 1'b0, 1'b0);
    check("start clears overflow", overflow[0], 0);

    // Abort: 5 bits discarded, restart with start+bit_vld carrying bit 0
    for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b1, 1'($urandom));
    cur_bits.delete();
    for (int i = 0; i < 8; i++) begin
      bit b;
      b = (i < 2) || (i > 5);
      cur_bits.push_back(b);
      step(0, i == 0, 1'b1, b);
    end
    check("abort first byte", out_data[0], 8'hC3);
    for (int i = 8; i < 114; i++) begin
      bit b;
      b = 1'($urandom);
      cur_bits.push_back(b);
      step(0, 1'b0, 1'b1, b);
    end
    drain(0);
    model_burst(0, 114, 1'b1);
    compare("abort");

    // Reset mid-burst with undrained bytes
    out_ready[0] = 1'b0;
    step(0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(0, 1'b0, 1'b1, 1'($urandom));
    check("midrst pre valid", out_valid[0], 1);
    rst_n = 1'b0;
    step(0, 1'b0, 1'b0, 1'b0);
    check("midrst valid", out_valid[0], 0);
    check("midrst busy", busy[0], 0);
    check("midrst overflow", overflow[0], 0);
    check("midrst data", out_data[0], 0);
    check("midrst nbits", out_nbits[0], 0);
    check("midrst last", out_last[0], 0);
    rst_n        = 1'b1;
    out_ready[0] = 1'b1;
    run_burst(0, 114, 1'b1, 0, 1'b0, "post reset");

    // Random bursts with bit_vld gaps and sink stalls
    for (int r = 0; r < 6; r++) run_burst(2, 13, 1'b0, 25, 1'b1, $sformatf("rand13 %0d", r));
    for (int r = 0; r < 4; r++) run_burst(1, 8, 1'b0, 25, 1'b1, $sformatf("rand8 %0d", r));
    for (int r = 0; r < 2; r++) run_burst(0, 114, 1'b1, 30, 1'b1, $sformatf("rand114 %0d", r));
    for (int d = 0; d < 3; d++) check($sformatf("final overflow%0d", d), overflow[d], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/a51_burst_packer.md
# a51_burst_packer

Downstream stage of the A5/1 keystream/cipher generator. It consumes the serial `Cipher` bit stream one bit per qualified clock, frames it into GSM bursts of `BURST_BITS` bits, and packs each burst into bytes on a valid/ready byte interface. The final partial byte is zero-padded, tagged with a last flag and a valid-bit count. The block reports overflow when the byte sink cannot keep up.

## Interface
Parameters:
- `BURST_BITS`, 114: bits per burst; legal range 1..1023.
- `MSB_FIRST`, 1: when 1, the first received bit lands in byte bit 7; when 0, it lands in bit 0.

Ports:
- `clk`  in  1  single clock; all logic samples on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  one-cycle pulse; begins a new burst.
- `bit_in`  in  1  serial cipher bit from the A5/1 stage.
- `bit_vld`  in  1  `bit_in` is valid this cycle; driven low while the cipher stage loads its key.
- `out_data`  out  8  packed byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts the byte.
- `out_last`  out  1  byte is the final byte of the burst.
- `out_nbits`  out  4  count of meaningful bits in `out_data`, 1..8; 8 for every non-last byte.
- `busy`  out  1  high while a burst is being collected.
- `overflow`  out  1  sticky flag; cleared only by reset or `start`.

## Operation
- FSM has two states: IDLE and COLLECT.
- IDLE:
  - `bit_vld` is ignored.
  - `start` moves the FSM to COLLECT and clears the bit counter, byte counter and shift register.
- COLLECT:
  - Each `bit_vld` shifts `bit_in` into the shift register and increments `bitcnt` (3 bits) and `burstcnt` (width `$clog2(BURST_BITS+1)`).
  - A byte is pushed when `bitcnt` wraps from 7 to 0, or when `burstcnt` reaches `BURST_BITS`.
- Partial last byte:
  - Bits are left-justified (MSB_FIRST=1) or right-justified (MSB_FIRST=0).
  - Unused positions are 0.
  - `out_nbits` is set to `BURST_BITS mod 8`, or 8 when that value is 0.
- After the last push, the FSM returns to IDLE and `busy` falls.
- `start` together with `bit_vld` in the same cycle:
  - Any burst in progress is aborted and its partial byte is discarded.
  - Bytes already queued are kept.
  - The bit is counted as bit 0 of the new burst.
- Output stage:
  - A byte transfers when `out_valid && out_ready`.
  - `out_data`, `out_last` and `out_nbits` stay stable while `out_valid && !out_ready`.
- Overflow:
  - If a push occurs while the output storage is full and no pop happens in the same cycle, the new byte is dropped and `overflow` sets.
  - A push and a pop in the same cycle on full storage is legal and does not set `overflow`.
- Reset mid-burst: all state is cleared and no partial byte is emitted.

## Timing
- Reset values:
  - `out_valid`, `out_last`, `busy`, `overflow`: 0.
  - `out_data`: 0x00.
  - `out_nbits`: 0.
  - FSM: IDLE.
- `busy` rises the cycle after `start`.
- Latency: `out_valid` asserts the cycle after the edge that samples the completing bit, provided storage was empty.
- Throughput: one bit per cycle. A byte is produced at most every 8 cycles, or more often for a burst shorter than 8 bits.
- `overflow` asserts the cycle after the dropped push.

## Configuration
- `A51_PACK_FIFO_EN` defined: output storage is a 4-entry byte FIFO, including the output register. Overflow occurs on the 5th unaccepted byte.
- Not defined: output storage is the single output register. Overflow occurs on the 2nd unaccepted byte.
- Port list is identical in both builds.

## Structure
- Shared package `a51_pkg` holds:
  - `A51_BURST_BITS = 114`.
  - `A51_BYTE_W = 8`.
  - FSM enum `a51_pack_state_t` (IDLE, COLLECT).
  - Typedef `a51_byte_t` for `{last, nbits[3:0], data[7:0]}`.
- One sub-module, `a51_byte_fifo`:
  - Depth parameter and synchronous active-low reset.
  - Instantiated only under `A51_PACK_FIFO_EN`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `bit_vld`=1 → `out_valid`=0, `busy`=0, `overflow`=0, `out_data`=0x00.
- Nominal, MSB_FIRST=1, `out_ready`=1: `start`, then 114 bits alternating 1,0 → 14 bytes of 0xAA with `out_nbits`=8, then 0x80 with `out_nbits`=2 and `out_last`=1; `busy` falls afterwards.
- MSB_FIRST=0, BURST_BITS=8: bits 1,0,0,0,0,0,0,0 → a single byte 0x01 with `out_last`=1 and `out_nbits`=8.
- Backpressure with `out_ready`=0 for the whole burst of all-ones:
  - No FIFO: first 0xFF is held and `overflow`=1 after bit 16.
  - FIFO build: `overflow`=1 after bit 40.
  - Then `out_ready`=1 drains 1 or 4 bytes of 0xFF respectively.
- Abort: `start`, 5 bits, then `start` with `bit_vld`=1 and 8 more bits of 0xC3 pattern (1,1,0,0,0,0,1,1) → the first byte out is 0xC3 and nothing from the aborted 5 bits appears.
- Reset mid-burst after 20 bits with 2 bytes undrained → all outputs return to reset values the next cycle; a following burst packs correctly from bit 0.
